mm_meas_view: RTL and testbench

Parametrised measurement/display stage for the multimeter. It sits between the SPI ADC front-end and the display/LED logic, and accepts CH_NR parallel ADC samples per update strobe. It keeps per-channel block average, max-hold and min-hold, and presents the selected channel/mode as a registered value plus a thermometer LED bar with timed peak-hold.

---
 rtl/mm_meas_view.sv | 196 +++++++++++++++++++
 tb/tb_mm_meas_view.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mm_meas_view.sv
// mm_meas_view: measurement/display stage for the multimeter.
// Takes CH_NR parallel ADC samples per update strobe. For every channel it keeps
// the last raw sample, max-hold, min-hold and a 2^AVG_LOG2 block average. It shows
// the selected channel/quantity as a registered value and as a thermometer LED
// bar with a timed peak-hold dot.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   din_i          CH_NR packed samples, channel c at [c*DATA_W +: DATA_W]
//   din_update_i   one-cycle strobe, din_i valid
//   ch_sel_i       selected channel; out-of-range values select channel 0
//   mode_i         00 raw, 01 block average, 10 max-hold, 11 min-hold
//   clr_i          clear statistics and peak; takes priority over din_update_i
//   value_o        displayed value (registered)
//   value_valid_o  one-cycle pulse when value_o is written
//   led_o          bar [lvl:0] plus peak dot, decoded from registers
//   overrange_o    selected channel's last raw sample was all ones
module mm_meas_view #(
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned CH_NR    = 2,
  parameter int unsigned AVG_LOG2 = 4,
  parameter int unsigned LED_NR   = 8,
  parameter int unsigned HOLD_CYC = 100_000_000,
  localparam int unsigned SEL_W   = (CH_NR > 1) ? $clog2(CH_NR) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CH_NR*DATA_W-1:0] din_i,
  input  logic                    din_update_i,
  input  logic [SEL_W-1:0]        ch_sel_i,
  input  logic [1:0]              mode_i,
  input  logic                    clr_i,
  output logic [DATA_W-1:0]       value_o,
  output logic                    value_valid_o,
  output logic [LED_NR-1:0]       led_o,
  output logic                    overrange_o
);

  localparam int unsigned ACC_W    = DATA_W + AVG_LOG2;
  localparam int unsigned LVL_BITS = $clog2(LED_NR);
  localparam int unsigned LVL_W    = (LVL_BITS > 0) ? LVL_BITS : 1;
  localparam int unsigned SHIFT    = DATA_W - LVL_BITS;
  localparam int unsigned HOLD_W   = $clog2(HOLD_CYC);

  logic [DATA_W-1:0] raw_q [CH_NR];
  logic [DATA_W-1:0] raw_d [CH_NR];
  logic [DATA_W-1:0] max_q [CH_NR];
  logic [DATA_W-1:0] max_d [CH_NR];
  logic [DATA_W-1:0] min_q [CH_NR];
  logic [DATA_W-1:0] min_d [CH_NR];
  logic [DATA_W-1:0] avg_q [CH_NR];
  logic [DATA_W-1:0] avg_d [CH_NR];
  logic [ACC_W-1:0]  acc_q [CH_NR];
  logic [ACC_W-1:0]  acc_d [CH_NR];
  logic [ACC_W-1:0]  acc_sum [CH_NR];
  logic [DATA_W-1:0] sample [CH_NR];

  logic [AVG_LOG2-1:0] cnt_q, cnt_d;
  logic                blk_done;
  logic                take;

  logic [DATA_W-1:0] sel_raw, sel_max, sel_min, sel_avg;
  logic [DATA_W-1:0] value_q, value_d;
  logic              valid_q, valid_d;
  logic              over_q, over_d;

  logic [LVL_W-1:0]  lvl;
  logic [LVL_W-1:0]  peak_q, peak_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  // Statistics next state, shared by all channels.
  always_comb begin
    take     = din_update_i & ~clr_i;
    blk_done = (cnt_q == '1);
    cnt_d    = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (din_update_i) begin
      cnt_d = cnt_q + 1'b1;  // wraps to 0 on block completion
    end
    for (int unsigned c = 0; c < CH_NR; c++) begin
      sample[c]  = din_i[c*DATA_W +: DATA_W];
      acc_sum[c] = acc_q[c] + ACC_W'(sample[c]);
      raw_d[c]   = raw_q[c];
      max_d[c]   = max_q[c];
      min_d[c]   = min_q[c];
      avg_d[c]   = avg_q[c];
      acc_d[c]   = acc_q[c];
      if (clr_i) begin
        max_d[c] = '0;
        min_d[c] = '1;
        acc_d[c] = '0;
      end else if (din_update_i) begin
        raw_d[c] = sample[c];
        max_d[c] = (sample[c] > max_q[c]) ? sample[c] : max_q[c];
        min_d[c] = (sample[c] < min_q[c]) ? sample[c] : min_q[c];
        if (blk_done) begin
          avg_d[c] = acc_sum[c][ACC_W-1:AVG_LOG2];
          acc_d[c] = '0;
        end else begin
          acc_d[c] = acc_sum[c];
        end
      end
    end
  end

  // Display uses the freshly updated statistics so value_o lags the strobe by one cycle.
  always_comb begin
    sel_raw = raw_d[0];
    sel_max = max_d[0];
    sel_min = min_d[0];
    sel_avg = avg_d[0];
    for (int unsigned c = 1; c < CH_NR; c++) begin
      if (32'(ch_sel_i) == c) begin
        sel_raw = raw_d[c];
        sel_max = max_d[c];
        sel_min = min_d[c];
        sel_avg = avg_d[c];
      end
    end

    value_d = value_q;
    valid_d = 1'b0;
    over_d  = over_q;
    if (take && ((mode_i != 2'b01) || blk_done)) begin
      valid_d = 1'b1;
      over_d  = &sel_raw;
      unique case (mode_i)
        2'b00: value_d = sel_raw;
        2'b01: value_d = sel_avg;
        2'b10: value_d = sel_max;
        2'b11: value_d = sel_min;
      endcase
    end
  end

  // Peak-hold: follow rises immediately, fall back to the current level on expiry.
  always_comb begin
    lvl    = LVL_W'(value_q >> SHIFT);
    peak_d = peak_q;
    hold_d = hold_q;
    if (clr_i) begin
      peak_d = '0;
      hold_d = HOLD_W'(HOLD_CYC - 1);
    end else if ((lvl > peak_q) || (hold_q == '0)) begin
      peak_d = lvl;
      hold_d = HOLD_W'(HOLD_CYC - 1);
    end else begin
      hold_d = hold_q - 1'b1;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < LED_NR; i++) begin
      led_o[i] = (32'(lvl) >= i) | (32'(peak_q) == i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < CH_NR; c++) begin
        raw_q[c] <= '0;
        max_q[c] <= '0;
        min_q[c] <= '1;
        avg_q[c] <= '0;
        acc_q[c] <= '0;
      end
      cnt_q   <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      over_q  <= 1'b0;
      peak_q  <= '0;
      hold_q  <= HOLD_W'(HOLD_CYC - 1);
    end else begin
      for (int unsigned c = 0; c < CH_NR; c++) begin
        raw_q[c] <= raw_d[c];
        max_q[c] <= max_d[c];
        min_q[c] <= min_d[c];
        avg_q[c] <= avg_d[c];
        acc_q[c] <= acc_d[c];
      end
      cnt_q   <= cnt_d;
      value_q <= value_d;
      valid_q <= valid_d;
      over_q  <= over_d;
      peak_q  <= peak_d;
      hold_q  <= hold_d;
    end
  end

  assign value_o       = value_q;
  assign value_valid_o = valid_q;
  assign overrange_o   = over_q;

endmodule

// File: tb/tb_mm_meas_view.sv
// Self-checking bench for mm_meas_view: table of directed strobes plus
// hand-written sequences for peak-hold timing, selection latching and mid-block reset.
module tb_mm_meas_view;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] c0, c1, c2;
  logic [35:0] din;
  logic        upd;
  logic [1:0]  sel;
  logic [1:0]  mode;
  logic        clr;
  logic [11:0] value;
  logic        valid;
  logic [7:0]  led;
  logic        over;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign din = {c2, c1, c0};

  mm_meas_view #(
    .DATA_W  (12),
    .CH_NR   (3),
    .AVG_LOG2(2),
    .LED_NR  (8),
    .HOLD_CYC(10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .din_i        (din),
    .din_update_i (upd),
    .ch_sel_i     (sel),
    .mode_i       (mode),
    .clr_i        (clr),
    .value_o      (value),
    .value_valid_o(valid),
    .led_o        (led),
    .overrange_o  (over)
  );

  typedef struct {
    logic [11:0] c0;
    logic [11:0] c1;
    logic [11:0] c2;
    logic [1:0]  sel;
    logic [1:0]  mode;
    logic        upd;
    logic        clr;
    logic        ev;
    logic [11:0] evalue;
    logic        eover;
    logic        chk_led;
    logic [7:0]  eled;
  } vec_t;

  vec_t vecs [18];
  logic [11:0] bseq [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  initial begin
    // c0, c1, c2, sel, mode, upd, clr, valid, value, over, chk_led, led
    vecs[0]  = '{12'h001, 12'h800, 12'h000, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{12'h002, 12'h800, 12'h000, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{12'h003, 12'h800, 12'h000, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{12'h006, 12'h800, 12'h000, 2'd0, 2'd1, 1'b1, 1'b0, 1'b1, 12'h003, 1'b0, 1'b1, 8'h01};
    vecs[4]  = '{12'h100, 12'h800, 12'h000, 2'd1, 2'd0, 1'b1, 1'b0, 1'b1, 12'h800, 1'b0, 1'b1, 8'h1F};
    vecs[5]  = '{12'h000, 12'h000, 12'h000, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0, 12'h800, 1'b0, 1'b0, 8'h00};
    vecs[6]  = '{12'h100, 12'h000, 12'h000, 2'd0, 2'd2, 1'b1, 1'b0, 1'b1, 12'h100, 1'b0, 1'b0, 8'h00};
    vecs[7]  = '{12'hF00, 12'h000, 12'h000, 2'd0, 2'd2, 1'b1, 1'b0, 1'b1, 12'hF00, 1'b0, 1'b0, 8'h00};
    vecs[8]  = '{12'h050, 12'h000, 12'h000, 2'd0, 2'd2, 1'b1, 1'b0, 1'b1, 12'hF00, 1'b0, 1'b0, 8'h00};
    vecs[9]  = '{12'h050, 12'h000, 12'h000, 2'd0, 2'd3, 1'b1, 1'b0, 1'b1, 12'h050, 1'b0, 1'b0, 8'h00};
    vecs[10] = '{12'h010, 12'h000, 12'h000, 2'd0, 2'd3, 1'b1, 1'b1, 1'b0, 12'h050, 1'b0, 1'b0, 8'h00};
    vecs[11] = '{12'h200, 12'h000, 12'h000, 2'd0, 2'd2, 1'b1, 1'b0, 1'b1, 12'h200, 1'b0, 1'b0, 8'h00};
    vecs[12] = '{12'h200, 12'h000, 12'h000, 2'd0, 2'd3, 1'b1, 1'b0, 1'b1, 12'h200, 1'b0, 1'b0, 8'h00};
    vecs[13] = '{12'hFFF, 12'h000, 12'h000, 2'd3, 2'd0, 1'b1, 1'b0, 1'b1, 12'hFFF, 1'b1, 1'b0, 8'h00};
    vecs[14] = '{12'hFFF, 12'h000, 12'h000, 2'd3, 2'd1, 1'b1, 1'b0, 1'b1, 12'h8FF, 1'b1, 1'b0, 8'h00};
    vecs[15] = '{12'h7FF, 12'h000, 12'h000, 2'd0, 2'd0, 1'b1, 1'b0, 1'b1, 12'h7FF, 1'b0, 1'b0, 8'h00};
    vecs[16] = '{12'h7FF, 12'h000, 12'h000, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 12'h7FF, 1'b0, 1'b0, 8'h00};
    vecs[17] = '{12'h000, 12'h000, 12'hABC, 2'd2, 2'd2, 1'b1, 1'b0, 1'b1, 12'hABC, 1'b0, 1'b0, 8'h00};
    bseq[0] = 12'h008;
    bseq[1] = 12'h008;
    bseq[2] = 12'h008;
    bseq[3] = 12'h004;

    rst  = 1'b1;
    c0   = '0;
    c1   = '0;
    c2   = '0;
    upd  = 1'b0;
    sel  = '0;
    mode = '0;
    clr  = 1'b0;
    #12;
    chk("reset value", 32'(value), 32'h0);
    chk("reset valid", 32'(valid), 32'h0);
    chk("reset over", 32'(over), 32'h0);
    chk("reset led", 32'(led), 32'h01);
    @(negedge clk);
    rst = 1'b0;

    // Table: each record is one strobe (or clear) followed by an idle cycle.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      c0   = vecs[i].c0;
      c1   = vecs[i].c1;
      c2   = vecs[i].c2;
      sel  = vecs[i].sel;
      mode = vecs[i].mode;
      upd  = vecs[i].upd;
      clr  = vecs[i].clr;
      @(negedge clk);
      upd = 1'b0;
      clr = 1'b0;
      chk($sformatf("v%0d valid", i), 32'(valid), 32'(vecs[i].ev));
      chk($sformatf("v%0d value", i), 32'(value), 32'(vecs[i].evalue));
      chk($sformatf("v%0d over", i), 32'(over), 32'(vecs[i].eover));
      if (vecs[i].chk_led) chk($sformatf("v%0d led", i), 32'(led), 32'(vecs[i].eled));
    end

    // Peak hold: settle to level 0, then full scale followed directly by zero.
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr  = 1'b0;
    c0   = 12'h000;
    c1   = 12'h000;
    c2   = 12'h000;
    sel  = 2'd0;
    mode = 2'd0;
    upd  = 1'b1;
    @(negedge clk);
    upd = 1'b0;
    repeat (12) @(negedge clk);
    chk("peak settled led", 32'(led), 32'h01);
    c0  = 12'hFFF;
    upd = 1'b1;
    @(negedge clk);
    c0 = 12'h000;
    chk("b2b first valid", 32'(valid), 32'h1);
    chk("b2b first value", 32'(value), 32'hFFF);
    chk("full scale led", 32'(led), 32'hFF);
    @(negedge clk);
    upd = 1'b0;
    chk("b2b second valid", 32'(valid), 32'h1);
    chk("b2b second value", 32'(value), 32'h000);
    chk("peak led 0", 32'(led), 32'h81);
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      if (k == 1) chk("after b2b valid", 32'(valid), 32'h0);
      chk($sformatf("peak led %0d", k), 32'(led), 32'h81);
    end
    @(negedge clk);
    chk("peak expired led", 32'(led), 32'h01);

    // Selection is latched at the strobe; later changes leave value_o alone.
    c0   = 12'h123;
    sel  = 2'd0;
    mode = 2'd0;
    upd  = 1'b1;
    @(negedge clk);
    upd = 1'b0;
    chk("latch value", 32'(value), 32'h123);
    sel  = 2'd1;
    mode = 2'd2;
    repeat (3) @(negedge clk);
    chk("latch hold value", 32'(value), 32'h123);
    chk("latch hold valid", 32'(valid), 32'h0);

    // Mid-block reset: outputs clear at once, partial sums are dropped.
    c0   = 12'hFFF;
    sel  = 2'd0;
    mode = 2'd0;
    upd  = 1'b1;
    @(negedge clk);
    upd = 1'b0;
    chk("pre-rst value", 32'(value), 32'hFFF);
    chk("pre-rst over", 32'(over), 32'h1);
    mode = 2'd1;
    c0   = 12'h100;
    upd  = 1'b1;
    @(negedge clk);
    upd = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid rst value", 32'(value), 32'h0);
    chk("mid rst valid", 32'(valid), 32'h0);
    chk("mid rst over", 32'(over), 32'h0);
    chk("mid rst led", 32'(led), 32'h01);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      c0  = bseq[k];
      upd = 1'b1;
      @(negedge clk);
      upd = 1'b0;
      chk($sformatf("post-rst avg valid %0d", k), 32'(valid), (k == 3) ? 32'h1 : 32'h0);
      if (k == 3) chk("post-rst avg value", 32'(value), 32'h007);
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
